csla_64: RTL and testbench
==========================

Name: csla_64

Overview:
- 64-bit carry-select adder with registered outputs: sum = a + b + cin, carry-out on cout.
- Datapath-level arithmetic block for use wherever a fast wide add is needed in the team's designs.
- Internally split into fixed-width ripple-carry groups. Each group above the lowest precomputes results for carry-in 0 and carry-in 1, then selects one by the incoming group carry.
- Result is captured in an output register on the clock edge.

Parameters:
- BLOCK_W, 4, bits per carry-select group. Must divide 64; legal values are 4, 8 and 16.

Ports:
- clk  input  1  clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- a  input  64  operand A, unsigned
- b  input  64  operand B, unsigned
- cin  input  1  carry-in
- sum  output  64  registered result bits [63:0] of a+b+cin
- cout  output  1  registered carry-out (bit 64 of a+b+cin)

Behaviour:
- Reset:
  - One clock; reset is asynchronous and active-low.
  - While rst_n=0, sum=64'd0 and cout=0 immediately, independent of clk.
  - On rst_n deassertion, outputs hold 0 until the next rising clk edge.
- Arithmetic:
  - {cout,sum} = a + b + cin, unsigned, 65-bit exact. No saturation, no overflow flag.
  - Wrap-around: a result of 2^64 or more sets cout=1; sum holds the low 64 bits.
- Latency:
  - Exactly 1 cycle. The sum/cout values after rising edge N reflect a/b/cin sampled at edge N.
  - Outputs are stable between edges.
  - No handshake, no valid signal; a new operand set is accepted every cycle.
- Structure:
  - Group 0 (bits [BLOCK_W-1:0]) is a single ripple-carry adder fed by cin.
  - Each higher group k has two ripple-carry adders, with carry-in fixed to 0 and to 1.
  - A 2:1 mux selects that group's sum bits and carry-out using the carry-out of group k-1.
  - The carry-out of the top group is cout.
  - The combinational path from a/b/cin to the register D inputs contains no storage.
- Boundary conditions:
  - All-ones plus carry (a=2^64-1, b=0, cin=1): sum=0, cout=1.
  - Carry must propagate through every group select.
  - a=b=2^64-1, cin=1: sum=2^64-1, cout=1.
  - Reset asserted mid-stream discards the in-flight result. The first post-reset edge registers the current inputs.
  - X or Z on an input is not required to produce defined outputs.

Test Plan:
- Hold rst_n=0 with arbitrary inputs and toggle clk -> sum=0, cout=0. Assert rst_n low asynchronously between edges -> outputs clear without waiting for an edge.
- Back-to-back vectors, one per cycle, each checked one cycle later:
  - a=2, b=2, cin=1 -> sum=5, cout=0.
  - a=2, b=4, cin=1 -> sum=7, cout=0.
  - a=100, b=0, cin=0 -> sum=100, cout=0.
- Large operands:
  - a=1234567890, b=11111111111111, cin=1 -> sum=11112345679002, cout=0.
  - a=1234567890, b=111123452, cin=1 -> sum=1345691343, cout=0.
- Full carry ripple: a=64'hFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> sum=0, cout=1. Then a=b=64'hFFFF_FFFF_FFFF_FFFF, cin=1 -> sum=64'hFFFF_FFFF_FFFF_FFFF, cout=1.
- Group-boundary carries, for each group boundary i (multiple of BLOCK_W): a=(1<<i)-1, b=1, cin=0 -> sum=1<<i, cout=0.
- Random regression: at least 10k random a/b/cin vectors per BLOCK_W in {4,8,16}, checked against a 65-bit behavioural add with 1-cycle delay. Include rst_n pulses mid-stream; require outputs of 0 during reset and correct results from the first post-reset edge.

Source files
------------

// File: rtl/csla_64.sv
// 64-bit carry-select adder with a registered {cout, sum} result.
// Groups of BLOCK_W bits ripple internally; upper groups pick between carry-in 0/1 results.
module csla_64 #(
  parameter int BLOCK_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  output logic [63:0] sum,
  output logic        cout
);

  localparam int DATA_W = 64;
  localparam int NGRP   = DATA_W / BLOCK_W;

  if (!(BLOCK_W == 4 || BLOCK_W == 8 || BLOCK_W == 16)) begin : g_bad_block_w
    $error("csla_64: BLOCK_W must be 4, 8 or 16");
  end

  // Plain ripple-carry group: returns {carry_out, sum_bits}.
  function automatic logic [BLOCK_W:0] ripple(input logic [BLOCK_W-1:0] x,
                                               input logic [BLOCK_W-1:0] y,
                                               input logic               ci);
    logic               c;
    logic [BLOCK_W-1:0] s;
    c = ci;
    for (int i = 0; i < BLOCK_W; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic [DATA_W-1:0] sum_d, sum_q;
  logic              cout_d, cout_q;
  logic [BLOCK_W:0]  grp0, grp1, sel;
  logic              carry;

  always_comb begin
    carry = cin;
    sum_d = '0;
    grp0  = '0;
    grp1  = '0;
    sel   = '0;
    for (int g = 0; g < NGRP; g++) begin
      grp0 = ripple(a[g*BLOCK_W +: BLOCK_W], b[g*BLOCK_W +: BLOCK_W], 1'b0);
      grp1 = ripple(a[g*BLOCK_W +: BLOCK_W], b[g*BLOCK_W +: BLOCK_W], 1'b1);
      if (g == 0) begin
        sel = ripple(a[BLOCK_W-1:0], b[BLOCK_W-1:0], cin);
      end else begin
        sel = carry ? grp1 : grp0;
      end
      sum_d[g*BLOCK_W +: BLOCK_W] = sel[BLOCK_W-1:0];
      carry = sel[BLOCK_W];
    end
    cout_d = carry;
  end

  // Output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum_d;
      cout_q <= cout_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_csla_64.sv
// Bench for csla_64: three instances (BLOCK_W 4/8/16) share stimulus and one scoreboard.
module tb_csla_64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        cin = 1'b0;
  logic [63:0] sum_o [3];
  logic        cout_o [3];

  int n_cmp = 0;
  int n_bad = 0;

  logic [64:0] sb[$];
  string       sb_name[$];

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        co;
  } vec_t;

  vec_t tbl [10];

  always #5 clk = ~clk;

  csla_64 #(.BLOCK_W(4))  u_b4  (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
                                 .sum(sum_o[0]), .cout(cout_o[0]));
  csla_64 #(.BLOCK_W(8))  u_b8  (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
                                 .sum(sum_o[1]), .cout(cout_o[1]));
  csla_64 #(.BLOCK_W(16)) u_b16 (.clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin),
                                 .sum(sum_o[2]), .cout(cout_o[2]));

  task automatic check(input string name, input logic [64:0] exp);
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if ({cout_o[k], sum_o[k]} !== exp) begin
        n_bad++;
        $display("FAIL %s dut%0d: got cout=%0b sum=%h, expected cout=%0b sum=%h",
                 name, k, cout_o[k], sum_o[k], exp[64], exp[63:0]);
      end
    end
  endtask

  task automatic pop_check();
    if (sb.size() > 0) check(sb_name.pop_front(), sb.pop_front());
  endtask

  // One vector per cycle: check the previous result, then drive the next operands.
  task automatic step(input logic [63:0] na, input logic [63:0] nb, input logic nc,
                      input logic [64:0] exp, input string name);
    @(negedge clk);
    pop_check();
    a   = na;
    b   = nb;
    cin = nc;
    sb.push_back(exp);
    sb_name.push_back(name);
  endtask

  task automatic drain();
    @(negedge clk);
    pop_check();
  endtask

  function automatic logic [64:0] model(input logic [63:0] x, input logic [63:0] y,
                                        input logic c);
    return {1'b0, x} + {1'b0, y} + {64'd0, c};
  endfunction

  // Asynchronous reset pulse between edges; leaves the first post-reset vector queued.
  task automatic reset_pulse(input int cycles, input logic [63:0] na,
                             input logic [63:0] nb, input logic nc);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset_clear", 65'd0);
    sb.delete();
    sb_name.delete();
    repeat (cycles) begin
      @(negedge clk);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      cin = 1'($urandom);
      @(posedge clk);
      #1 check("reset_hold", 65'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("post_deassert_hold", 65'd0);
    a   = na;
    b   = nb;
    cin = nc;
    sb.push_back(model(na, nb, nc));
    sb_name.push_back("first_post_reset");
  endtask

  initial begin
    tbl[0] = '{64'd2, 64'd2, 1'b1, 64'd5, 1'b0};
    tbl[1] = '{64'd2, 64'd4, 1'b1, 64'd7, 1'b0};
    tbl[2] = '{64'd100, 64'd0, 1'b0, 64'd100, 1'b0};
    tbl[3] = '{64'd1234567890, 64'd11111111111111, 1'b1, 64'd11112345679002, 1'b0};
    tbl[4] = '{64'd1234567890, 64'd111123452, 1'b1, 64'd1345691343, 1'b0};
    tbl[5] = '{64'd0, 64'd0, 1'b0, 64'd0, 1'b0};
    tbl[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'd0, 1'b1};
    tbl[7] = '{64'h5555_5555_5555_5555, 64'hAAAA_AAAA_AAAA_AAAA, 1'b1, 64'd0, 1'b1};
    tbl[8] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1};
    tbl[9] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 1'b1};

    // Reset asserted before any clock edge must clear outputs at once.
    a = 64'hDEAD_BEEF_0123_4567;
    b = 64'h0FED_CBA9_8765_4321;
    cin = 1'b1;
    #1 rst_n = 1'b0;
    #1 check("reset_async_initial", 65'd0);
    repeat (3) begin
      @(posedge clk);
      #1 check("reset_clocked", 65'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("deassert_hold", 65'd0);

    for (int i = 0; i < 10; i++)
      step(tbl[i].a, tbl[i].b, tbl[i].cin, {tbl[i].co, tbl[i].s}, $sformatf("tbl%0d", i));
    drain();

    for (int i = 4; i < 64; i += 4) begin
      logic [63:0] one;
      logic [63:0] ones;
      one  = 64'd1 << i;
      ones = one - 64'd1;
      step(ones, 64'd1, 1'b0, {1'b0, one}, $sformatf("grp_boundary_%0d", i));
    end
    step(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {1'b1, 64'd0}, "grp_boundary_64");
    drain();

    // Outputs are non-zero here, so the async clear is observable.
    reset_pulse(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

    for (int n = 0; n < 10000; n++) begin
      logic [63:0] ra;
      logic [63:0] rb;
      logic        rc;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rc = 1'($urandom);
      if ($urandom_range(0, 7) == 0) rb = ~ra;
      if (n % 2500 == 1250) begin
        drain();
        reset_pulse(int'($urandom_range(1, 3)), ra, rb, rc);
      end else begin
        step(ra, rb, rc, model(ra, rb, rc), "random");
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
